// File: rtl/mac_feeder_if.sv
// mac_feeder_if: operand-pair stream into the mac feeder FIFO
interface mac_feeder_if #(parameter int bw = 8);
    logic          in_valid;
    logic          in_ready;
    logic [bw-1:0] in_a;
    logic [bw-1:0] in_b;
    modport master (output in_valid, in_a, in_b, input in_ready);
    modport slave  (input in_valid, in_a, in_b, output in_ready);
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder: FIFO-buffered operand sequencer running one dot-product job on a downstream mac
module mac_feeder #(
    parameter int bw      = 8,
    parameter int psum_bw = 16,
    parameter int len_bw  = 4,
    parameter int depth   = 4,
    parameter int mac_lat = 1
) (
    input  logic               clk,
    input  logic               reset,
    mac_feeder_if.slave        op,
    input  logic               start,
    input  logic [len_bw-1:0]  len,
    input  logic               fmt,
    output logic               busy,
    output logic               mac_clr,
    output logic [bw-1:0]      A,
    output logic [bw-1:0]      B,
    output logic               acc,
    output logic               format,
    input  logic [psum_bw-1:0] mac_out,
    output logic [psum_bw-1:0] result,
    output logic               result_valid,
    output logic               sat
);
    localparam int aw = $clog2(depth) > 0 ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);
    localparam int dw = mac_lat > 1 ? $clog2(mac_lat) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, CAPTURE} state_t;

    state_t              state;
    logic [2*bw-1:0]     mem [depth];
    logic [aw-1:0]       wp, rp;
    logic [cw-1:0]       count;
    logic [len_bw-1:0]   len_q, cnt;
    logic [dw-1:0]       dcnt;
    logic                push, pop;
    logic [bw:0]         ca, cb;

    // returns {saturated, converted operand}; -2^(bw-1) has no magnitude, so clamp it
    function automatic logic [bw:0] conv(input logic [bw-1:0] x, input logic sm);
        logic [bw-1:0] n;
        n = -x;
        conv = !sm || !x[bw-1] ? {1'b0, x}
             : x == {1'b1, {(bw-1){1'b0}}} ? {1'b1, {bw{1'b1}}}
             : {2'b01, n[bw-2:0]};
    endfunction

    assign op.in_ready = count != cw'(depth);
    assign push        = op.in_valid && op.in_ready;
    assign pop         = count != '0 && (state == CLEAR || (state == STREAM && cnt != len_q));
    assign busy        = state != IDLE;
    assign ca          = conv(mem[rp][2*bw-1:bw], format);
    assign cb          = conv(mem[rp][bw-1:0], format);

    always_ff @(posedge clk)
        if (push) mem[wp] <= {op.in_a, op.in_b};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            len_q        <= '0;
            cnt          <= '0;
            dcnt         <= '0;
            A            <= '0;
            B            <= '0;
            acc          <= 1'b0;
            format       <= 1'b0;
            mac_clr      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            sat          <= 1'b0;
        end else begin
            wp           <= wp + aw'(push);
            rp           <= rp + aw'(pop);
            count        <= count + cw'(push) - cw'(pop);
            mac_clr      <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: if (start && len != '0) begin
                    len_q   <= len;
                    format  <= fmt;
                    cnt     <= '0;
                    sat     <= 1'b0;
                    mac_clr <= 1'b1;
                    acc     <= 1'b0;
                    A       <= '0;
                    B       <= '0;
                    state   <= CLEAR;
                end
                // the first term leaves on the CLEAR edge; an empty FIFO becomes a zero bubble
                CLEAR, STREAM: if (state == STREAM && cnt == len_q) begin
                    A     <= '0;
                    B     <= '0;
                    acc   <= 1'b1;
                    dcnt  <= '0;
                    state <= DRAIN;
                end else begin
                    A     <= pop ? ca[bw-1:0] : '0;
                    B     <= pop ? cb[bw-1:0] : '0;
                    acc   <= 1'b1;
                    cnt   <= cnt + len_bw'(pop);
                    sat   <= sat | (pop & (ca[bw] | cb[bw]));
                    state <= STREAM;
                end
                DRAIN: if (dcnt == dw'(mac_lat - 1)) begin
                    acc   <= 1'b0;
                    state <= CAPTURE;
                end else begin
                    dcnt  <= dcnt + 1'b1;
                end
                CAPTURE: begin
                    result       <= mac_out;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed checks of mac_feeder against a behavioural mac model
module tb_mac_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        fmt = 1'b0;
    logic        busy, mac_clr, acc, format, result_valid, sat;
    logic [7:0]  A, B;
    logic [15:0] mac_out, result;
    logic [15:0] ev [8];
    int          n_chk = 0;
    int          n_pass = 0;

    mac_feeder_if #(.bw(8)) op ();

    mac_feeder dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .len(len), .fmt(fmt),
        .busy(busy), .mac_clr(mac_clr), .A(A), .B(B), .acc(acc), .format(format),
        .mac_out(mac_out), .result(result), .result_valid(result_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic int sval(input logic [7:0] x, input logic sm);
        return sm ? (x[7] ? -int'(x[6:0]) : int'(x[6:0])) : int'($signed(x));
    endfunction

    always_ff @(posedge clk or posedge reset)
        if (reset) mac_out <= '0;
        else if (mac_clr) mac_out <= '0;
        else if (acc) mac_out <= mac_out + 16'(sval(A, format) * sval(B, format));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        op.in_valid = 1'b1;
        op.in_a = a;
        op.in_b = b;
        tick;
        op.in_valid = 1'b0;
    endtask

    task automatic job(input logic [3:0] l, input logic fm);
        start = 1'b1;
        len = l;
        fmt = fm;
        tick;
        start = 1'b0;
        chk("clear", {mac_clr, busy, acc, A, B}, {3'b110, 16'h0});
        for (int k = 0; k < int'(l); k++) begin
            tick;
            chk("term", {format, acc, A, B}, {fm, 1'b1, ev[k]});
        end
        repeat (2) begin
            tick;
            chk("rv_early", {result_valid, busy}, 2'b01);
        end
        tick;
        chk("rv", {result_valid, busy}, 2'b10);
    endtask

    initial begin
        op.in_valid = 1'b0;
        op.in_a = '0;
        op.in_b = '0;
        #2;
        chk("reset_out", {A, B, acc, format, mac_clr, busy, result_valid, sat}, 0);
        chk("reset_ready", {op.in_ready, result}, {1'b1, 16'h0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick;

        push(8'd1, 8'd2); push(8'd3, 8'd4); push(-8'sd5, 8'd6); push(8'd7, -8'sd8);
        ev[0] = 16'h0102; ev[1] = 16'h0304; ev[2] = 16'hFB06; ev[3] = 16'h07F8;
        job(4'd4, 1'b0);
        chk("res_2c", result, 16'hFFB8);
        tick;
        chk("rv_pulse", {result_valid, result}, {1'b0, 16'hFFB8});

        push(8'd1, 8'd2); push(8'd3, 8'd4); push(-8'sd5, 8'd6); push(8'd7, -8'sd8);
        ev[0] = 16'h0102; ev[1] = 16'h0304; ev[2] = 16'h8506; ev[3] = 16'h0788;
        job(4'd4, 1'b1);
        chk("res_sm", {result, sat, format}, {16'hFFB8, 1'b0, 1'b1});

        push(8'h80, 8'd1);
        ev[0] = 16'hFF01;
        job(4'd1, 1'b1);
        chk("res_sat", {result, sat}, {16'hFF81, 1'b1});

        push(8'd1, 8'd1); push(8'd2, 8'd2); push(8'd3, 8'd3);
        chk("ready_3", op.in_ready, 1);
        push(8'd4, 8'd4);
        chk("ready_full", op.in_ready, 0);
        op.in_valid = 1'b1; op.in_a = 8'd5; op.in_b = 8'd5;
        tick;
        op.in_valid = 1'b0;
        chk("held_off", {op.in_ready, busy}, 2'b00);
        ev[0] = 16'h0101; ev[1] = 16'h0202; ev[2] = 16'h0303; ev[3] = 16'h0404;
        start = 1'b1; len = 4'd8; fmt = 1'b0;
        tick;
        start = 1'b0;
        chk("trk_clear", {mac_clr, busy}, 2'b11);
        for (int t = 1; t <= 16; t++) begin
            tick;
            if (t <= 4) chk("trk_term", {acc, A, B}, {1'b1, ev[t-1]});
            else if (t <= 13) chk("trk_term", {acc, A, B},
                {1'b1, t == 5 ? 16'h0505 : t == 7 ? 16'h0606 : t == 10 ? 16'h0707 : t == 13 ? 16'h0808 : 16'h0000});
            else if (t == 15) chk("trk_rv_early", result_valid, 0);
            else if (t == 16) chk("trk_res", {result_valid, result}, {1'b1, 16'h00CC});
            op.in_valid = t == 2 || t == 5 || t == 8 || t == 11;
            op.in_a = t == 2 ? 8'd5 : t == 5 ? 8'd6 : t == 8 ? 8'd7 : 8'd8;
            op.in_b = op.in_a;
        end
        op.in_valid = 1'b0;

        start = 1'b1; len = 4'd0;
        tick;
        start = 1'b0;
        chk("len0", {busy, mac_clr}, 2'b00);
        tick; tick;
        chk("len0_rv", {result_valid, result}, {1'b0, 16'h00CC});

        push(8'd2, 8'd3); push(8'd4, 8'd5);
        start = 1'b1; len = 4'd2; fmt = 1'b0;
        tick;
        len = 4'd1;
        tick;
        start = 1'b0;
        chk("busy_t0", {busy, acc, A, B}, {2'b11, 16'h0203});
        tick;
        chk("busy_t1", {acc, A, B}, {1'b1, 16'h0405});
        tick; tick;
        chk("busy_rv_early", result_valid, 0);
        tick;
        chk("busy_res", {result_valid, result}, {1'b1, 16'h001A});
        tick; tick;
        chk("busy_after", {busy, result_valid, mac_clr}, 3'b000);

        push(8'd1, 8'd1); push(8'd2, 8'd2); push(8'd3, 8'd3);
        start = 1'b1; len = 4'd3; fmt = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        chk("pre_abort", {busy, A, format}, {1'b1, 8'd2, 1'b1});
        #2 reset = 1'b1;
        #1;
        chk("abort_out", {A, B, acc, format, mac_clr, busy, result_valid, sat}, 0);
        chk("abort_res", {op.in_ready, result}, {1'b1, 16'h0});
        @(negedge clk);
        reset = 1'b0;
        tick;
        push(8'd3, -8'sd2);
        ev[0] = 16'h03FE;
        job(4'd1, 1'b0);
        chk("res_after_abort", result, 16'hFFFA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
